// File: rtl/ppc_sequencer.sv
// ppc_sequencer: runs an external ping-pong counter for a programmed number of
// direction reversals, then reports completion (done) or abort (aborted).
// Optional feature macro: PPC_SEQ_PAUSE_EN adds the pause input and PAUSE state.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, stop         run request (IDLE only) / abort request (any active state)
//   pause               (PPC_SEQ_PAUSE_EN only) hold the counter mid-run
//   target              reversals to run, latched on accepted start
//   cnt_dir, cnt_out    direction and value from the sequenced counter
//   cnt_enable, busy    registered counter enable / run-in-progress flag
//   done, aborted       one-cycle completion / abort pulses
//   bounce_cnt          reversals counted in the current or last run
//   last_val            cnt_out captured when the run ended
module ppc_sequencer #(
    parameter int CNT_W = 4,
    parameter int BNC_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
`ifdef PPC_SEQ_PAUSE_EN
    input  logic             pause,
`endif
    input  logic [BNC_W-1:0] target,
    input  logic             cnt_dir,
    input  logic [CNT_W-1:0] cnt_out,
    output logic             cnt_enable,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [BNC_W-1:0] bounce_cnt,
    output logic [CNT_W-1:0] last_val
);
`ifdef PPC_SEQ_PAUSE_EN
    typedef enum logic [1:0] {IDLE, RUN, FIN, PAUSE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
`endif
    state_t           state_q, state_d;
    logic [BNC_W-1:0] tgt_q, tgt_d, bounce_cnt_q, bounce_cnt_d;
    logic [CNT_W-1:0] last_val_q, last_val_d;
    logic             dir_q, dir_d, cnt_enable_q, cnt_enable_d, busy_q, busy_d;
    logic             done_q, done_d, aborted_q, aborted_d, bounce;

    assign bounce = cnt_dir != dir_q;

    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        bounce_cnt_d = bounce_cnt_q;
        last_val_d   = last_val_q;
        dir_d        = cnt_dir;
        cnt_enable_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        case (state_q)
            IDLE: if (start && !stop) begin
                tgt_d        = target;
                bounce_cnt_d = '0;
                if (target == '0) begin
                    state_d    = FIN;
                    done_d     = 1'b1;
                    last_val_d = cnt_out;
                end else begin
                    state_d      = RUN;
                    cnt_enable_d = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            RUN: begin
                // stop has priority over a completing bounce in the same cycle
                if (stop) begin
                    state_d    = IDLE;
                    aborted_d  = 1'b1;
                    last_val_d = cnt_out;
                end else if (bounce && (bounce_cnt_q + BNC_W'(1)) == tgt_q) begin
                    state_d      = FIN;
                    bounce_cnt_d = tgt_q;
                    done_d       = 1'b1;
                    last_val_d   = cnt_out;
                end else begin
                    // bounce_cnt_q < tgt_q here, so the increment cannot wrap
                    if (bounce) bounce_cnt_d = bounce_cnt_q + BNC_W'(1);
                    busy_d = 1'b1;
`ifdef PPC_SEQ_PAUSE_EN
                    if (pause) state_d = PAUSE;
                    else cnt_enable_d = 1'b1;
`else
                    cnt_enable_d = 1'b1;
`endif
                end
            end
            FIN: state_d = IDLE;
`ifdef PPC_SEQ_PAUSE_EN
            // counter is frozen here; dir_q keeps tracking so resume sees no false bounce
            PAUSE: if (stop) begin
                state_d    = IDLE;
                aborted_d  = 1'b1;
                last_val_d = cnt_out;
            end else begin
                busy_d = 1'b1;
                if (!pause) begin
                    state_d      = RUN;
                    cnt_enable_d = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tgt_q        <= '0;
            bounce_cnt_q <= '0;
            last_val_q   <= '0;
            dir_q        <= 1'b1;
            cnt_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            bounce_cnt_q <= bounce_cnt_d;
            last_val_q   <= last_val_d;
            dir_q        <= dir_d;
            cnt_enable_q <= cnt_enable_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    assign cnt_enable = cnt_enable_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign bounce_cnt = bounce_cnt_q;
    assign last_val   = last_val_q;
endmodule

// File: tb/tb_ppc_sequencer.sv
// tb_ppc_sequencer: scoreboard bench for ppc_sequencer driving a bench-side
// 4-bit ping-pong counter; expected run results come from a phase-based model.
module tb_ppc_sequencer;
    localparam int CW = 4;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          pause = 1'b0;
    logic [BW-1:0] target = '0;
    logic          cnt_dir;
    logic [CW-1:0] cnt_out;
    logic          cnt_enable, busy, done, aborted;
    logic [BW-1:0] bounce_cnt;
    logic [CW-1:0] last_val;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        bit is_done;
        int bcnt;
        int lval;
    } exp_t;
    exp_t sb[$];

    ppc_sequencer #(.CNT_W(CW), .BNC_W(BW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
`ifdef PPC_SEQ_PAUSE_EN
        .pause(pause),
`endif
        .target(target), .cnt_dir(cnt_dir), .cnt_out(cnt_out),
        .cnt_enable(cnt_enable), .busy(busy), .done(done), .aborted(aborted),
        .bounce_cnt(bounce_cnt), .last_val(last_val)
    );

    always #5 clk = ~clk;

    // Ping-pong counter: reverses on reaching 15 and 0, dir flips with the value.
    logic [3:0] c_val = 4'd0;
    logic       c_dir = 1'b1;
    assign cnt_out = c_val;
    assign cnt_dir = c_dir;
    always @(posedge clk) begin
        if (cnt_enable) begin
            c_val <= c_dir ? c_val + 4'd1 : c_val - 4'd1;
            if (c_dir && c_val == 4'd14) c_dir <= 1'b0;
            else if (!c_dir && c_val == 4'd1) c_dir <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Counter position as phase 0..29 on a 30-step cycle; reversal seen when phase hits 0 or 15.
    function automatic int ph_val(input int p);
        return (p <= 15) ? p : 30 - p;
    endfunction

    task automatic model(input int v0, input bit d0, input int t, input int stop_at,
                         output exp_t e, output int n_end);
        int p0, cnt, pk;
        p0 = d0 ? v0 : 30 - v0;
        cnt = 0;
        n_end = 0;
        e.is_done = 1'b1; e.bcnt = 0; e.lval = v0;
        if (t == 0) return;
        for (int k = 0; k < 1000; k++) begin
            pk = (p0 + k) % 30;
            if (k == stop_at) begin
                e.is_done = 1'b0; e.bcnt = cnt; e.lval = ph_val(pk); n_end = k;
                return;
            end
            if (k > 0 && (pk == 0 || pk == 15)) cnt++;
            if (cnt == t) begin
                e.is_done = 1'b1; e.bcnt = t; e.lval = ph_val(pk); n_end = k;
                return;
            end
        end
    endtask

    // Monitor: pops an expectation for every done/aborted pulse.
    logic prev_pulse = 1'b0;
    always @(negedge clk) begin
        if (rst_n && (done || aborted)) begin
            chk("pulse_one_cycle", prev_pulse, 0);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {done, aborted}, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done", done, e.is_done);
                chk("aborted", aborted, !e.is_done);
                chk("bounce_cnt", bounce_cnt, e.bcnt);
                chk("last_val", last_val, e.lval);
                chk("enable_off_at_end", cnt_enable, 0);
            end
        end
        prev_pulse <= done || aborted;
    end

    task automatic wait_empty();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Must be called at a negedge. stop_at = RUN-cycle index to assert stop (-1: never).
    task automatic run(input int t, input int stop_at);
        exp_t e;
        int   n_end;
        model(int'(c_val), c_dir, t, stop_at, e, n_end);
        sb.push_back(e);
        start = 1'b1;
        target = BW'(t);
        @(negedge clk);
        start = 1'b0;
        target = BW'($urandom);
        if (t == 0) begin
            chk("t0_enable_never", cnt_enable, 0);
        end else begin
            for (int k = 0; k <= n_end; k++) begin
                chk("run_enable", cnt_enable, 1);
                chk("run_busy", busy, 1);
                stop = (k == stop_at);
                start = 1'($urandom);
                target = BW'($urandom);
                @(negedge clk);
            end
        end
        stop = 1'b0;
        start = 1'b0;
        wait_empty();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_cnt_enable"}, cnt_enable, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_aborted"}, aborted, 0);
        chk({tag, "_bounce_cnt"}, bounce_cnt, 0);
        chk({tag, "_last_val"}, last_val, 0);
    endtask

    initial begin
        exp_t e;
        int   n;
        #1 rst_n = 1'b0;
        #1 chk_zero("reset");
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run(3, -1);
        run(0, -1);

        model(int'(c_val), c_dir, 2, -1, e, n);
        run(5, n + 1);

        model(int'(c_val), c_dir, 1, -1, e, n);
        run(1, n);

        start = 1'b1; stop = 1'b1; target = 4'd3;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("start_stop_idle_busy", busy, 0);
        chk("start_stop_idle_enable", cnt_enable, 0);
        repeat (3) @(negedge clk);

        start = 1'b1; target = 4'd5;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && bounce_cnt != 4'd2; i++) @(negedge clk);
        chk("midrun_reached_2", bounce_cnt, 2);
        #2 rst_n = 1'b0;
        #1 chk_zero("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run(2, -1);

`ifdef PPC_SEQ_PAUSE_EN
        begin
            logic [BW-1:0] b;
            model(int'(c_val), c_dir, 2, -1, e, n);
            sb.push_back(e);
            start = 1'b1; target = 4'd2;
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(negedge clk);
            pause = 1'b1;
            b = bounce_cnt;
            repeat (10) begin
                @(negedge clk);
                chk("pause_enable", cnt_enable, 0);
                chk("pause_busy", busy, 1);
                chk("pause_bounce_hold", bounce_cnt, b);
            end
            pause = 1'b0;
            wait_empty();
        end
`endif

        for (int r = 0; r < 24; r++) begin
            int t, s;
            t = int'($urandom_range(0, 6));
            s = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 60));
            run(t, s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ppc_sequencer.md
PPC_SEQUENCER -- requirements
Module: ppc_sequencer

Interface
REQ-001 Parameter CNT_W, default 4: width of the sequenced ping-pong counter value.
REQ-002 Parameter BNC_W, default 4: width of the bounce target and bounce counter.
REQ-003 The block SHALL have these ports:
- clk  input  1  single clock; all state on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a run; sampled only in IDLE.
- stop  input  1  abort request; effective in any non-IDLE state.
- target  input  BNC_W  number of direction reversals to run; latched on accepted start.
- cnt_dir  input  1  direction output of the sequenced counter (1 = counting up).
- cnt_out  input  CNT_W  value output of the sequenced counter; monitored only.
- cnt_enable  output  1  registered enable to the counter.
- busy  output  1  high in RUN (and PAUSE, when configured).
- done  output  1  one-cycle pulse on normal completion.
- aborted  output  1  one-cycle pulse on stop-terminated run.
- bounce_cnt  output  BNC_W  reversals counted in the current or last run.
- last_val  output  CNT_W  cnt_out captured on the cycle the run ends.

Function
REQ-004 The block SHALL implement states IDLE, RUN, FIN (plus PAUSE under REQ-016); all outputs are registered.
REQ-005 IDLE with start=1 and stop=0 SHALL latch target, clear bounce_cnt and enter RUN; cnt_enable and busy SHALL be 1 the next cycle.
REQ-006 An accepted start with target=0 SHALL go directly to FIN; cnt_enable SHALL never assert.
REQ-007 In RUN, a bounce SHALL be counted on each cycle where cnt_dir differs from its value registered the previous cycle (dir_q, updated every cycle).
REQ-008 When a bounce brings bounce_cnt equal to the latched target, the block SHALL enter FIN and deassert cnt_enable on the same edge; bounce_cnt SHALL hold at target.
REQ-009 FIN SHALL last exactly one cycle with done=1 and last_val=cnt_out captured at entry, then return to IDLE.
REQ-010 stop=1 in RUN SHALL enter IDLE next edge with cnt_enable=0, aborted=1 for one cycle, last_val captured, and bounce_cnt held.
REQ-011 stop and a completing bounce in the same cycle: stop SHALL win (aborted, no done).
REQ-012 start and stop together in IDLE: SHALL remain in IDLE with no pulse.
REQ-013 start outside IDLE SHALL be ignored; target changes after acceptance SHALL have no effect.
REQ-014 bounce_cnt SHALL never wrap; done and aborted SHALL never assert together.

Reset
REQ-015 rst_n=0 SHALL immediately force IDLE, cnt_enable=0, busy=0, done=0, aborted=0, bounce_cnt=0, last_val=0, dir_q=1, independent of clk, including mid-run.

Configuration
REQ-016 With PPC_SEQ_PAUSE_EN defined, an input pause (1 bit) and state PAUSE SHALL exist: RUN with pause=1 enters PAUSE (cnt_enable=0, busy=1, bounce detection frozen, dir_q updated). PAUSE with pause=0 SHALL return to RUN. stop SHALL still abort from PAUSE.
REQ-017 Without PPC_SEQ_PAUSE_EN there SHALL be no pause port and no PAUSE state; behaviour is exactly REQ-004..REQ-015.

Verification
REQ-018 Reset, then start with target=3 driving a real 4-bit ping-pong counter -> cnt_enable 1 for the whole run, done pulses once after the 3rd reversal, bounce_cnt=3, last_val=0 or 15.
REQ-019 target=0 start -> FIN next cycle, done=1 for one cycle, cnt_enable stays 0.
REQ-020 target=5, stop after 2 bounces -> aborted=1 one cycle, bounce_cnt=2, no done, IDLE.
REQ-021 stop on the same cycle as the completing bounce (target=1) -> aborted=1, done=0.
REQ-022 rst_n low mid-run with bounce_cnt=2 -> all outputs 0 asynchronously; a new start after release runs normally.
REQ-023 With PPC_SEQ_PAUSE_EN, pause held 10 cycles mid-run -> cnt_enable=0, bounce_cnt unchanged, busy=1; the run resumes and completes with done.
